// File: rtl/io_bus_master_pkg.sv
// io_bus_master_pkg: shared bus-state encodings, width default and device addresses
package io_bus_master_pkg;
  localparam int DBITS_DEFAULT = 32;
  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ST   = 2'd1,
    BUS_LD   = 2'd2
  } bus_state_t;
  localparam logic [31:0] LEDR_ADDR  = 32'hFFFFF020;
  localparam logic [31:0] SW_ADDR    = 32'hFFFFF040;
  localparam logic [31:0] KEY_ADDR   = 32'hFFFFF080;
  localparam logic [31:0] TIMER_ADDR = 32'hFFFFF100;
endpackage

// File: rtl/io_store_fifo.sv
// io_store_fifo: small circular buffer holding pipeline stores until the bus takes them
module io_store_fifo #(
  parameter int DEPTH   = 4,
  parameter int PTRBITS = 2,
  parameter int W       = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [W-1:0]       wdata,
  output logic               full,
  output logic               empty,
  output logic [PTRBITS:0]   count,
  output logic [W-1:0]       head
);
  logic [W-1:0]       mem [DEPTH];
  logic [PTRBITS-1:0] hd, tl;
  logic               do_push, do_pop;
  assign full    = count == (PTRBITS+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[hd];
  // pointer and occupancy bookkeeping; simultaneous push and pop keep count steady
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      hd    <= hd + PTRBITS'(do_pop);
      tl    <= tl + PTRBITS'(do_push);
      count <= count + (PTRBITS+1)'(do_push) - (PTRBITS+1)'(do_pop);
    end
  // entry storage needs no reset; occupancy alone says what is valid
  always_ff @(posedge clk)
    if (do_push) mem[tl] <= wdata;
endmodule

// File: rtl/io_bus_master.sv
// io_bus_master: buffers MEM-stage stores, drains them to the device bus, then issues loads
module io_bus_master import io_bus_master_pkg::*; #(
  parameter int DBITS   = DBITS_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int PTRBITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [DBITS-1:0] req_addr,
  input  logic [DBITS-1:0] req_wdata,
  output logic             req_stall,
  output logic [DBITS-1:0] rdata,
  output logic             rdata_valid,
  output logic [DBITS-1:0] addrbus,
  inout  wire  [DBITS-1:0] databus,
  output logic             ld,
  output logic             sw
);
  bus_state_t         state, next_state;
  logic [DBITS-1:0]   wdata_q;
  logic [2*DBITS-1:0] head;
  logic [PTRBITS:0]   count;
  logic               full, empty, push, pop, ld_busy, ld_acc;
  io_store_fifo #(.DEPTH(DEPTH), .PTRBITS(PTRBITS), .W(2*DBITS)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({req_addr, req_wdata}),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );
  assign ld_busy   = state != BUS_IDLE | rdata_valid;
  assign ld_acc    = req_valid & ~req_we & count == '0 & ~ld_busy;
  assign push      = req_valid & req_we & ~full;
  assign pop       = ~empty;
  assign req_stall = req_valid & (req_we ? full : ~ld_acc);
  assign databus   = sw ? wdata_q : 'z;
  // a load can only be accepted with an empty buffer, so load issue and store pop never collide
  always_comb begin
    next_state = BUS_IDLE;
    next_state = ld_acc ? BUS_LD : pop ? BUS_ST : next_state;
  end
  // registered bus drive and load capture; strobes follow the next bus state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= BUS_IDLE;
      addrbus     <= '0;
      wdata_q     <= '0;
      ld          <= 1'b0;
      sw          <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      state       <= next_state;
      ld          <= next_state == BUS_LD;
      sw          <= next_state == BUS_ST;
      addrbus     <= ld_acc ? req_addr : pop ? head[2*DBITS-1:DBITS] : addrbus;
      wdata_q     <= pop ? head[DBITS-1:0] : wdata_q;
      rdata_valid <= state == BUS_LD;
      rdata       <= state == BUS_LD ? databus : rdata;
    end
endmodule
